block_data_memory: RTL and testbench

//  Word-organised data memory answering the data cache's block requests on the Mem_* interface.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 44 ++++
 rtl/block_data_memory.sv | 134 +++++++++++++
 tb/tb_block_data_memory.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the block data memory.
// The state encoding, default geometry and counter widths live here.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LATENCY = 5;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W  = 4;

  // Width of the optional read/write statistics counters.
  localparam int STAT_W = 16;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the block data memory: 2**ADDR_W words of DATA_W bits.
// Synchronous write and synchronous read with a read enable, so the read
// register holds its value between reads. Reset clears every word and the
// read register in a single cycle.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Clear on reset; otherwise commit a write and/or load the read register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata_reg <= '0;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      if (re) begin
        rdata_reg <= mem[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/block_data_memory.sv
// Block data memory responder for the data cache's Mem_* interface.
// One read or write per request; BusyWait stays high for LATENCY+1 cycles,
// then drops for the single DONE cycle to signal completion.
// Optional feature: define DMEM_STATS_EN to add the Read_Count/Write_Count
// saturating statistics outputs.
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              BusyWait
`ifdef DMEM_STATS_EN
  ,
  output logic [STAT_W-1:0] Read_Count,
  output logic [STAT_W-1:0] Write_Count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              wr_op_reg, wr_op_next;
  logic              mem_we;
  logic              mem_re;

  // State, latency counter and captured request; reset aborts any request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wr_op_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wr_op_reg <= wr_op_next;
    end
  end

  // Next-state logic: accept in IDLE, count down in ACCESS, commit on zero.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wr_op_next = wr_op_reg;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Read || Write) begin
          // Write wins when both are requested.
          addr_next  = Address;
          wdata_next = WriteData;
          wr_op_next = Write;
          cnt_next   = CNT_LOAD;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          // Commit even if the initiator has dropped its request.
          mem_we     = wr_op_reg;
          mem_re     = !wr_op_reg;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        // Never accepts here: guarantees one IDLE cycle between requests.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // High in IDLE with a request so the initiator never sees a false completion.
  assign BusyWait = !Reset && (Read || Write) && (state_reg != DONE);

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_reg),
    .wdata (wdata_reg),
    .rdata (ReadData)
  );

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] read_count_reg;
  logic [STAT_W-1:0] write_count_reg;

  // Saturating counts of committed reads and writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_count_reg  <= '0;
      write_count_reg <= '0;
    end else begin
      if (mem_re && (read_count_reg != '1)) begin
        read_count_reg <= read_count_reg + 1'b1;
      end
      if (mem_we && (write_count_reg != '1)) begin
        write_count_reg <= write_count_reg + 1'b1;
      end
    end
  end

  assign Read_Count  = read_count_reg;
  assign Write_Count = write_count_reg;
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Directed, table-driven bench for block_data_memory.
// Optional statistics outputs are checked when DMEM_STATS_EN is defined.
module tb_block_data_memory;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Read;
  logic        Write;
  logic [5:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        BusyWait;
`ifdef DMEM_STATS_EN
  logic [15:0] Read_Count;
  logic [15:0] Write_Count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_reads  = 0;
  int exp_writes = 0;

  localparam int EXP_BUSY = 6;

  block_data_memory dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Read      (Read),
    .Write     (Write),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .BusyWait  (BusyWait)
`ifdef DMEM_STATS_EN
    ,
    .Read_Count  (Read_Count),
    .Write_Count (Write_Count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request, count BusyWait-high cycles, return ReadData seen in DONE.
  // Address/WriteData are scrambled after acceptance to show they are ignored.
  task automatic run_req(input logic rd, input logic wr, input logic [5:0] a,
                         input logic [31:0] d, output int busy, output logic [31:0] rdata);
    @(posedge Clk);
    #1;
    Read = rd; Write = wr; Address = a; WriteData = d;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (BusyWait) busy++;
      else break;
      if (busy >= 2) begin
        Address   = ~a;
        WriteData = ~d;
      end
    end
    rdata = ReadData;
    Read = 1'b0; Write = 1'b0;
    if (wr) exp_writes++;
    else if (rd) exp_reads++;
  endtask

  initial begin
    int          busy;
    logic [31:0] rdata;

    vecs[0]  = '{1'b1, 1'b0, 6'h05, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 6'h11, 32'h01020304, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 6'h31, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 1'b0, 6'h11, 32'h0,        32'h01020304};
    vecs[6]  = '{1'b1, 1'b1, 6'h03, 32'hA5A5A5A5, 32'h01020304};
    vecs[7]  = '{1'b1, 1'b0, 6'h03, 32'h0,        32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 1'b1, 6'h3F, 32'h12345678, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'h12345678};
    vecs[10] = '{1'b1, 1'b0, 6'h00, 32'h0,        32'h0};

    // Reset with a request present: BusyWait must be forced low.
    Reset = 1'b1; Read = 1'b1; Write = 1'b0; Address = '0; WriteData = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_busywait", {31'b0, BusyWait}, 32'h0);
    check("reset_readdata", ReadData, 32'h0);
    Read = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    for (int v = 0; v < 11; v++) begin
      run_req(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, busy, rdata);
      $display("txn %0d rd=%b wr=%b addr=%h wdata=%h busy=%0d rdata=%h",
               v, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, busy, rdata);
      check($sformatf("vec%0d_busy", v), busy, EXP_BUSY);
      check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
    end

    // Request dropped right after acceptance still commits.
    @(posedge Clk);
    #1;
    Write = 1'b1; Address = 6'h20; WriteData = 32'h00000055;
    @(negedge Clk);
    check("drop_busy_idle", {31'b0, BusyWait}, 32'h1);
    @(posedge Clk);
    #1;
    Write = 1'b0;
    #1;
    check("drop_busy_low", {31'b0, BusyWait}, 32'h0);
    exp_writes++;
    repeat (8) @(posedge Clk);
    run_req(1'b1, 1'b0, 6'h20, 32'h0, busy, rdata);
    $display("txn drop_readback addr=20 busy=%0d rdata=%h", busy, rdata);
    check("drop_readback", rdata, 32'h00000055);

`ifdef DMEM_STATS_EN
    check("stats_reads", {16'b0, Read_Count}, exp_reads);
    check("stats_writes", {16'b0, Write_Count}, exp_writes);
`endif

    // Reset in the third ACCESS cycle of a write aborts it.
    @(posedge Clk);
    #1;
    Write = 1'b1; Address = 6'h07; WriteData = 32'hFFFFFFFF;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_busywait", {31'b0, BusyWait}, 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    Write = 1'b0;
    Reset = 1'b0;
    exp_reads = 0;
    exp_writes = 0;
    check("abort_readdata_cleared", ReadData, 32'h0);
`ifdef DMEM_STATS_EN
    check("stats_reads_reset", {16'b0, Read_Count}, 32'h0);
    check("stats_writes_reset", {16'b0, Write_Count}, 32'h0);
`endif
    run_req(1'b1, 1'b0, 6'h07, 32'h0, busy, rdata);
    $display("txn abort_readback addr=07 busy=%0d rdata=%h", busy, rdata);
    check("abort_busy", busy, EXP_BUSY);
    check("abort_readback", rdata, 32'h0);
    run_req(1'b1, 1'b0, 6'h2A, 32'h0, busy, rdata);
    $display("txn cleared_readback addr=2A busy=%0d rdata=%h", busy, rdata);
    check("cleared_readback", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
